// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, flit-type codes and the injector FSM states.
package noc_pkg;

  localparam int FLIT_W      = 64;
  localparam int NUM_VC      = 2;
  localparam int COORD_W     = 3;
  localparam int LEN_W       = 3;
  localparam int HEAD_DATA_W = 50;
  localparam int BODY_DATA_W = 62;

  localparam int TYPE_HI  = 63;
  localparam int TYPE_LO  = 62;
  localparam int DX_HI    = 61;
  localparam int DX_LO    = 59;
  localparam int DY_HI    = 58;
  localparam int DY_LO    = 56;
  localparam int SX_HI    = 55;
  localparam int SX_LO    = 53;
  localparam int SY_HI    = 52;
  localparam int SY_LO    = 50;
  localparam int HDATA_HI = 49;

  typedef enum logic [1:0] {
    FT_HEAD   = 2'b00,
    FT_BODY   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2
  } ni_state_e;

  function automatic logic [FLIT_W-1:0] make_head(
    input flit_type_e               ftype,
    input logic [COORD_W-1:0]       dx,
    input logic [COORD_W-1:0]       dy,
    input logic [COORD_W-1:0]       sx,
    input logic [COORD_W-1:0]       sy,
    input logic [HEAD_DATA_W-1:0]   data
  );
    return {ftype, dx, dy, sx, sy, data};
  endfunction

endpackage

// File: rtl/ni_credit_counter.sv
// Per-VC credit counter for the router local input buffer, with sticky overflow flag.
module ni_credit_counter #(
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             send,
  input  logic             credit,
  output logic [CNT_W-1:0] count,
  output logic             nonzero,
  output logic             overflow
);

  logic [CNT_W-1:0] count_q;
  logic             ovf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= CNT_W'(BUF_DEPTH);
      ovf_q   <= 1'b0;
    end else begin
      case ({send, credit})
        2'b10: if (count_q != '0) count_q <= count_q - 1'b1;
        2'b01: begin
          // A credit with the buffer already fully free is a protocol error.
          if (count_q == CNT_W'(BUF_DEPTH)) ovf_q   <= 1'b1;
          else                              count_q <= count_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign count    = count_q;
  assign nonzero  = (count_q != '0);
  assign overflow = ovf_q;

endmodule

// File: rtl/ni_injector.sv
// Network-interface injector: turns packet requests plus body words into
// credit-flow-controlled flits for the router local port.
module ni_injector #(
  parameter int BUF_DEPTH = 4,
  parameter int NUM_VC    = noc_pkg::NUM_VC
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [noc_pkg::COORD_W-1:0]       router_x,
  input  logic [noc_pkg::COORD_W-1:0]       router_y,
  input  logic                              pkt_valid,
  output logic                              pkt_ready,
  input  logic [noc_pkg::COORD_W-1:0]       pkt_dest_x,
  input  logic [noc_pkg::COORD_W-1:0]       pkt_dest_y,
  input  logic [noc_pkg::LEN_W-1:0]         pkt_len,
  input  logic [noc_pkg::HEAD_DATA_W-1:0]   pkt_head_data,
  input  logic                              data_valid,
  output logic                              data_ready,
  input  logic [noc_pkg::BODY_DATA_W-1:0]   data_in,
  output logic [noc_pkg::FLIT_W-1:0]        flit_out,
  output logic                              flit_out_valid,
  output logic [NUM_VC-1:0]                 flit_out_vc,
  input  logic [NUM_VC-1:0]                 credit_in,
  output logic                              credit_err
);
  import noc_pkg::*;

  localparam int CNT_W    = $clog2(BUF_DEPTH + 1);
  localparam int VC_IDX_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

  ni_state_e             state_q, state_d;
  logic [VC_IDX_W-1:0]   rr_q, vc_q, sel_vc;
  logic                  sel_found;
  logic [LEN_W-1:0]      len_q, bcnt_q;
  logic                  load_head, load_data, is_tail;
  logic [NUM_VC-1:0]     nz, ovf_vc, send_vc;
  logic [CNT_W-1:0]      cnt [NUM_VC];

  logic [FLIT_W-1:0]     flit_p1;
  logic [NUM_VC-1:0]     vc_oh_p1;
  logic                  vld_p1;

  function automatic logic [NUM_VC-1:0] vc_onehot(input logic [VC_IDX_W-1:0] i);
    vc_onehot    = '0;
    vc_onehot[i] = 1'b1;
  endfunction

  for (genvar g = 0; g < NUM_VC; g++) begin : gen_cc
    ni_credit_counter #(.BUF_DEPTH(BUF_DEPTH), .CNT_W(CNT_W)) u_cc (
      .clk      (clk),
      .rst      (rst),
      .send     (send_vc[g]),
      .credit   (credit_in[g]),
      .count    (cnt[g]),
      .nonzero  (nz[g]),
      .overflow (ovf_vc[g])
    );
  end

  // Round-robin: first credited VC at or after the priority pointer.
  always_comb begin
    int idx;
    sel_vc    = '0;
    sel_found = 1'b0;
    for (int k = 0; k < NUM_VC; k++) begin
      idx = (int'(rr_q) + k) % NUM_VC;
      if (!sel_found && nz[idx]) begin
        sel_found = 1'b1;
        sel_vc    = VC_IDX_W'(idx);
      end
    end
  end

  // The head flit is built straight from the request so it appears the cycle
  // after acceptance; HEAD is the cycle it sits on the wire, and the first
  // body word may already be accepted then to keep flits back-to-back.
  always_comb begin
    state_d    = state_q;
    pkt_ready  = 1'b0;
    data_ready = 1'b0;
    load_head  = 1'b0;
    load_data  = 1'b0;
    is_tail    = (bcnt_q == len_q - 3'd1);
    case (state_q)
      ST_IDLE: begin
        pkt_ready = rst && sel_found;
        if (pkt_valid && pkt_ready) begin
          load_head = 1'b1;
          state_d   = ST_HEAD;
        end
      end
      ST_HEAD: begin
        if (len_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          data_ready = rst && nz[vc_q];
          state_d    = ST_BODY;
          if (data_valid && data_ready) begin
            load_data = 1'b1;
            if (is_tail) state_d = ST_IDLE;
          end
        end
      end
      ST_BODY: begin
        data_ready = rst && nz[vc_q];
        if (data_valid && data_ready) begin
          load_data = 1'b1;
          if (is_tail) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    send_vc = '0;
    if (load_head)      send_vc = vc_onehot(sel_vc);
    else if (load_data) send_vc = vc_onehot(vc_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      vld_p1  <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_p1  <= load_head || load_data;
      if (load_head)
        rr_q <= (int'(sel_vc) == NUM_VC - 1) ? '0 : sel_vc + 1'b1;
    end
  end

  // ---- stage p1: flit output register ----
  always_ff @(posedge clk) begin
    if (load_head) begin
      flit_p1  <= make_head((pkt_len == '0) ? FT_SINGLE : FT_HEAD,
                            pkt_dest_x, pkt_dest_y, router_x, router_y, pkt_head_data);
      vc_oh_p1 <= vc_onehot(sel_vc);
      vc_q     <= sel_vc;
      len_q    <= pkt_len;
      bcnt_q   <= '0;
    end else if (load_data) begin
      flit_p1  <= {(is_tail ? FT_TAIL : FT_BODY), data_in};
      vc_oh_p1 <= vc_onehot(vc_q);
      bcnt_q   <= bcnt_q + 1'b1;
    end
  end

  assign flit_out       = vld_p1 ? flit_p1 : '0;
  assign flit_out_vc    = vld_p1 ? vc_oh_p1 : '0;
  assign flit_out_valid = vld_p1;
  assign credit_err     = |ovf_vc;

endmodule

// File: tb/tb_ni_injector.sv
// Directed self-checking bench for ni_injector (BUF_DEPTH 4, two VCs).
module tb_ni_injector;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  router_x, router_y;
  logic        pkt_valid, pkt_ready;
  logic [2:0]  pkt_dest_x, pkt_dest_y, pkt_len;
  logic [49:0] pkt_head_data;
  logic        data_valid, data_ready;
  logic [61:0] data_in;
  logic [63:0] flit_out;
  logic        flit_out_valid;
  logic [1:0]  flit_out_vc;
  logic [1:0]  credit_in;
  logic        credit_err;

  int n_tests = 0;
  int n_fail  = 0;

  ni_injector #(.BUF_DEPTH(4), .NUM_VC(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .router_x      (router_x),
    .router_y      (router_y),
    .pkt_valid     (pkt_valid),
    .pkt_ready     (pkt_ready),
    .pkt_dest_x    (pkt_dest_x),
    .pkt_dest_y    (pkt_dest_y),
    .pkt_len       (pkt_len),
    .pkt_head_data (pkt_head_data),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .data_in       (data_in),
    .flit_out      (flit_out),
    .flit_out_valid(flit_out_valid),
    .flit_out_vc   (flit_out_vc),
    .credit_in     (credit_in),
    .credit_err    (credit_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    pkt_valid = 1'b0; data_valid = 1'b0; credit_in = 2'b00;
    tick; tick;
    rst = 1'b1;
    #1;
  endtask

  task automatic req(input logic [2:0] dx, input logic [2:0] dy,
                     input logic [2:0] len, input logic [49:0] hd);
    pkt_valid = 1'b1; pkt_dest_x = dx; pkt_dest_y = dy;
    pkt_len = len; pkt_head_data = hd;
  endtask

  logic [63:0] exp_flit;
  logic [61:0] wa, wb, wc, wd;
  int          vcount;

  initial begin
    rst = 1'b0;
    router_x = 3'd1; router_y = 3'd2;
    pkt_valid = 1'b0; pkt_dest_x = '0; pkt_dest_y = '0; pkt_len = '0; pkt_head_data = '0;
    data_valid = 1'b0; data_in = '0; credit_in = 2'b00;
    wa = 62'h0AAA_0000_1111; wb = 62'h0BBB_0000_2222;
    wc = 62'h0CCC_0000_3333; wd = 62'h0DDD_0000_4444;

    tick; tick;
    chk("rst_valid", flit_out_valid, 0);
    chk("rst_flit", flit_out, 0);
    chk("rst_pkt_ready", pkt_ready, 0);
    chk("rst_data_ready", data_ready, 0);
    chk("rst_err", credit_err, 0);
    chk("rst_cnt0", dut.cnt[0], 4);
    rst = 1'b1;
    #1;

    // Single-flit packet to (3,0)
    req(3'd3, 3'd0, 3'd0, 50'h123);
    #1 chk("s1_pkt_ready", pkt_ready, 1);
    tick;
    pkt_valid = 1'b0;
    exp_flit = {2'b11, 3'd3, 3'd0, 3'd1, 3'd2, 50'h123};
    chk("s1_valid", flit_out_valid, 1);
    chk("s1_flit", flit_out, exp_flit);
    chk("s1_vc", flit_out_vc, 2'b01);
    chk("s1_cnt0", dut.cnt[0], 3);
    tick;
    chk("s1_valid_drop", flit_out_valid, 0);
    chk("s1_flit_zero", flit_out, 0);
    chk("s1_vc_zero", flit_out_vc, 0);

    // Two single-flit packets back-to-back alternate VCs
    do_reset;
    req(3'd4, 3'd4, 3'd0, 50'h1);
    tick;
    chk("rr_first_vc", flit_out_vc, 2'b01);
    pkt_head_data = 50'h2;
    tick;
    chk("rr_gap_valid", flit_out_valid, 0);
    tick;
    pkt_valid = 1'b0;
    chk("rr_second_vc", flit_out_vc, 2'b10);
    chk("rr_second_data", flit_out[49:0], 50'h2);
    chk("rr_cnt1", dut.cnt[1], 3);
    credit_in = 2'b11;
    tick;
    credit_in = 2'b00;
    chk("rr_cnt0_back", dut.cnt[0], 4);
    chk("rr_cnt1_back", dut.cnt[1], 4);

    // len 3 packet, continuous data: head, A, B, C on consecutive cycles (VC0)
    req(3'd2, 3'd1, 3'd3, 50'h2AAAA);
    tick;
    pkt_valid = 1'b0;
    exp_flit = {2'b00, 3'd2, 3'd1, 3'd1, 3'd2, 50'h2AAAA};
    chk("l3_head", flit_out, exp_flit);
    chk("l3_head_vc", flit_out_vc, 2'b01);
    data_valid = 1'b1; data_in = wa;
    #1 chk("l3_data_ready", data_ready, 1);
    chk("l3_pkt_ready_excl", pkt_ready, 0);
    tick;
    chk("l3_body_a", flit_out, {2'b01, wa});
    chk("l3_body_a_vc", flit_out_vc, 2'b01);
    data_in = wb;
    tick;
    chk("l3_body_b", flit_out, {2'b01, wb});
    data_in = wc;
    tick;
    chk("l3_tail_c", flit_out, {2'b10, wc});
    chk("l3_tail_vc", flit_out_vc, 2'b01);
    data_valid = 1'b0;
    tick;
    chk("l3_after_valid", flit_out_valid, 0);
    chk("l3_cnt0", dut.cnt[0], 0);

    // 5-flit packet on VC0 with no credit return stalls before the tail
    do_reset;
    req(3'd5, 3'd6, 3'd4, 50'h3);
    tick;
    pkt_valid = 1'b0;
    chk("st_head_type", flit_out[63:62], 2'b00);
    data_valid = 1'b1; data_in = wa;
    tick;
    chk("st_b1", flit_out, {2'b01, wa});
    data_in = wb;
    tick;
    chk("st_b2", flit_out, {2'b01, wb});
    data_in = wc;
    tick;
    chk("st_b3", flit_out, {2'b01, wc});
    data_in = wd;
    #1 chk("st_data_ready_low", data_ready, 0);
    chk("st_cnt0_zero", dut.cnt[0], 0);
    tick;
    chk("st_stall1", flit_out_valid, 0);
    credit_in = 2'b01;
    tick;
    credit_in = 2'b00;
    chk("st_stall2", flit_out_valid, 0);
    chk("st_cnt0_one", dut.cnt[0], 1);
    #1 chk("st_data_ready_back", data_ready, 1);
    tick;
    data_valid = 1'b0;
    chk("st_tail", flit_out, {2'b10, wd});
    chk("st_tail_vc", flit_out_vc, 2'b01);

    // Credit overflow on VC1, then send+credit in one cycle on VC1
    credit_in = 2'b10;
    tick;
    credit_in = 2'b00;
    chk("ov_err_set", credit_err, 1);
    chk("ov_cnt1_hold", dut.cnt[1], 4);
    tick;
    chk("ov_err_sticky", credit_err, 1);
    req(3'd0, 3'd0, 3'd0, 50'h4);
    credit_in = 2'b10;
    tick;
    pkt_valid = 1'b0; credit_in = 2'b00;
    chk("ov_send_vc", flit_out_vc, 2'b10);
    chk("ov_cnt1_same", dut.cnt[1], 4);
    chk("ov_err_still", credit_err, 1);

    // Reset in the middle of a body sequence
    do_reset;
    chk("rr_err_clear", credit_err, 0);
    req(3'd1, 3'd1, 3'd3, 50'h5);
    tick;
    pkt_valid = 1'b0;
    data_valid = 1'b1; data_in = wa;
    tick;
    chk("mr_body_a", flit_out, {2'b01, wa});
    data_in = wb;
    #2 rst = 1'b0;
    #1;
    chk("mr_valid_now", flit_out_valid, 0);
    chk("mr_flit_now", flit_out, 0);
    chk("mr_vc_now", flit_out_vc, 0);
    chk("mr_data_ready_now", data_ready, 0);
    tick;
    rst = 1'b1;
    #1;
    chk("mr_cnt0", dut.cnt[0], 4);
    chk("mr_cnt1", dut.cnt[1], 4);
    vcount = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (flit_out_valid) vcount++;
    end
    data_valid = 1'b0;
    chk("mr_no_tail", vcount, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ni_injector.md
NI_INJECTOR -- requirements
Module: ni_injector

Interface
REQ-001 Parameter BUF_DEPTH, default 4: flit slots per VC in the router local input buffer, which is also the initial credit count per VC.
REQ-002 Parameter NUM_VC, default 2: number of virtual channels.
REQ-003 Port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-low reset (asserted when 0).
REQ-005 Port router_x / router_y, input, 3 each: coordinates of the attached router, used as the source field of head flits.
REQ-006 Port pkt_valid / pkt_ready, input / output, 1 each: packet-request handshake; the request transfers in a cycle where both are 1.
REQ-007 Port pkt_dest_x / pkt_dest_y, input, 3 each: destination coordinates.
REQ-008 Port pkt_len, input, 3: number of body flits, 0..7.
REQ-009 Port pkt_head_data, input, 50: head payload.
REQ-010 Port data_valid / data_ready, input / output, 1 each: body-payload handshake; a word transfers in a cycle where both are 1.
REQ-011 Port data_in, input, 62: body payload word.
REQ-012 Port flit_out, output, 64: flit, driving router peIn.
REQ-013 Port flit_out_valid, output, 1: flit valid, driving peIn_valid.
REQ-014 Port flit_out_vc, output, 2: VC of the flit, one-hot (01 = VC0, 10 = VC1), driving peIn_vc.
REQ-015 Port credit_in, input, 2: one-cycle pulse per VC (bit i = VC i), meaning one buffer slot freed; driven from router local_credits_out.
REQ-016 Port credit_err, output, 1: sticky flag set on credit overflow.

Function
REQ-017 Flit format: [63:62] type (00 head, 01 body, 10 tail, 11 single = head+tail).
REQ-018 Head and single flits: [61:59] dest_x, [58:56] dest_y, [55:53] src_x, [52:50] src_y, [49:0] pkt_head_data.
REQ-019 Body and tail flits: [61:0] data_in.
REQ-020 FSM states: IDLE, HEAD, BODY.
REQ-021 In IDLE, pkt_ready = 1 only when at least one VC holds a nonzero credit.
REQ-022 On a pkt_valid && pkt_ready transfer: latch dest, len and head data; select a VC; go to HEAD.
REQ-023 VC selection is round-robin among VCs with nonzero credit, starting after the last used VC; after reset VC0 has priority.
REQ-024 The selected VC is held for the entire packet (wormhole).
REQ-025 In HEAD, when credit[vc] > 0, emit a registered head flit (single flit if len = 0): flit_out_valid = 1 for exactly one cycle.
REQ-026 After the head flit, go to IDLE if len = 0, else to BODY.
REQ-027 In BODY, data_ready = 1 iff credit[vc] > 0.
REQ-028 Each data handshake in BODY emits one flit in the next cycle: body type, or tail type for the len-th word; after the tail flit, go to IDLE.
REQ-029 Latency: a request accepted in cycle N gives a head flit valid in cycle N+1 when credit is available.
REQ-030 Back-to-back flits are allowed: one flit per cycle maximum.
REQ-031 Credit counter per VC, range 0..BUF_DEPTH: decrement on each flit sent on that VC; increment on credit_in[i].
REQ-032 Simultaneous send and credit on the same VC leave the counter unchanged.
REQ-033 A credit arriving when the counter equals BUF_DEPTH (with no simultaneous send) holds the counter at BUF_DEPTH and sets credit_err until reset.
REQ-034 A flit is never emitted on a VC whose counter is 0; at zero credits the FSM stalls in place.
REQ-035 When flit_out_valid = 0, flit_out and flit_out_vc are driven 0.
REQ-036 pkt_ready and data_ready are never both 1 in the same cycle.

Reset
REQ-037 While rst = 0, immediately: state IDLE, credits = BUF_DEPTH per VC, round-robin pointer = VC0, credit_err = 0, flit_out = 0, flit_out_valid = 0, flit_out_vc = 0, pkt_ready = 0, data_ready = 0.
REQ-038 A packet in progress when reset is asserted is abandoned; no tail flit is emitted after reset is released.

Structure
REQ-039 Shared package noc_pkg holds: FLIT_W = 64, NUM_VC, flit-type codes, header field bit positions, and the coordinate width of 3.
REQ-040 One sub-module, ni_credit_counter (one counter per VC, with overflow flag), is instantiated NUM_VC times.

Verification
REQ-041 Scenario: reset, router at (1,2), request dest (3,0), len 0 -> one flit one cycle later: type 11, [61:50] = dest 3,0 / src 1,2, vc = 01, VC0 credit = 3.
REQ-042 Scenario: len 3, data words A, B, C presented continuously -> flits head, body A, body B, tail C on four consecutive cycles, all on the same VC.
REQ-043 Scenario: no credit_in, 5-flit packet on VC0 with BUF_DEPTH 4 -> four flits are sent, data_ready drops, a stall follows; one credit_in[0] pulse -> tail flit released.
REQ-044 Scenario: two single-flit packets back-to-back with both VCs credited -> first on vc 01, second on vc 10.
REQ-045 Scenario: credit_in[1] pulse while VC1 counter = 4 -> credit_err = 1 and stays 1; counter remains 4; send and credit in the same cycle -> counter unchanged.
REQ-046 Scenario: rst asserted mid-BODY -> outputs 0 at once; after release, credits = 4 and no tail flit is emitted.
